// File: rtl/alu_pkg.sv
// Shared ALU widths, function codes and legality check.
// Used by the operand/issue stage and the ALU proper.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUFN_W = 6;

  localparam logic [ALUFN_W-1:0] ALU_ADD = 6'b000000;
  localparam logic [ALUFN_W-1:0] ALU_SUB = 6'b000001;
  localparam logic [ALUFN_W-1:0] ALU_MUL = 6'b000010;
  localparam logic [ALUFN_W-1:0] ALU_AND = 6'b000100;
  localparam logic [ALUFN_W-1:0] ALU_OR  = 6'b000101;
  localparam logic [ALUFN_W-1:0] ALU_XOR = 6'b000110;
  localparam logic [ALUFN_W-1:0] ALU_SLL = 6'b001000;
  localparam logic [ALUFN_W-1:0] ALU_SRL = 6'b001001;
  localparam logic [ALUFN_W-1:0] ALU_SLT = 6'b001011;

  function automatic logic alufn_is_legal(
    input logic [ALUFN_W-1:0] f
  );
    logic ok;
    ok = 1'b0;
    case (f)
      ALU_ADD, ALU_SUB, ALU_MUL,
      ALU_AND, ALU_OR,  ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SLT: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_operand_issue_if.sv
// Issue, ALU-side and writeback signals of the operand stage.
// slave = the issue stage, master = its environment.
interface alu_operand_issue_if
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic               in_valid;
  logic               in_ready;
  logic [ALUFN_W-1:0] in_alufn;
  logic [AW-1:0]      in_rs1;
  logic [AW-1:0]      in_rs2;
  logic               in_use_imm;
  logic [DW-1:0]      in_imm;
  logic [AW-1:0]      in_rd;

  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_a;
  logic [DW-1:0]      out_b;
  logic [ALUFN_W-1:0] out_alufn;
  logic [AW-1:0]      out_rd;
  logic               out_illegal;

  logic               wb_en;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;

  modport slave (
    input  in_valid, in_alufn, in_rs1, in_rs2,
    input  in_use_imm, in_imm, in_rd,
    output in_ready,
    output out_valid, out_a, out_b, out_alufn,
    output out_rd, out_illegal,
    input  out_ready,
    input  wb_en, wb_addr, wb_data
  );

  modport master (
    output in_valid, in_alufn, in_rs1, in_rs2,
    output in_use_imm, in_imm, in_rd,
    input  in_ready,
    input  out_valid, out_a, out_b, out_alufn,
    input  out_rd, out_illegal,
    output out_ready,
    output wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file, 2 read / 1 write ports.
// Reg 0 reads zero; a same-cycle write is seen by reads.
module regfile_2r1w
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = 32,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NR];

  // Storage; writes to reg 0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports with write-through bypass.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Operand/issue stage: scoreboard, hazard check and
// registered operand hand-off to the ALU.
module alu_operand_issue
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NUM_REGS = 32,
  parameter int AW = ADDR_W
) (
  input logic clk,
  input logic rst,
  alu_operand_issue_if.slave bus
);

  logic [DW-1:0]       rd1;
  logic [DW-1:0]       rd2;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic fwd1, fwd2, wb_rd;
  logic haz1, haz2, waw, hazard;
  logic legal, accept;

  regfile_2r1w #(
    .DW(DW), .NR(NUM_REGS), .AW(AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (bus.in_rs1),
    .raddr2 (bus.in_rs2),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data)
  );

  // Hazard detection and the input handshake.
  always_comb begin
    legal  = alufn_is_legal(bus.in_alufn);
    fwd1   = bus.wb_en && bus.wb_addr == bus.in_rs1;
    fwd2   = bus.wb_en && bus.wb_addr == bus.in_rs2;
    wb_rd  = bus.wb_en && bus.wb_addr == bus.in_rd;
    haz1   = bus.in_rs1 != '0 && pending[bus.in_rs1]
             && !fwd1;
    haz2   = !bus.in_use_imm && bus.in_rs2 != '0
             && pending[bus.in_rs2] && !fwd2;
    waw    = legal && bus.in_rd != '0
             && pending[bus.in_rd] && !wb_rd;
    hazard = haz1 || haz2 || waw;
    bus.in_ready = (!bus.out_valid || bus.out_ready)
                   && !hazard;
    accept = bus.in_valid && bus.in_ready;
  end

  // Scoreboard update: clear on writeback, set on issue.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_en) pending_nxt[bus.wb_addr] = 1'b0;
    if (accept && legal && bus.in_rd != '0)
      pending_nxt[bus.in_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Output register towards the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_a       <= '0;
      bus.out_b       <= '0;
      bus.out_alufn   <= '0;
      bus.out_rd      <= '0;
      bus.out_illegal <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_a       <= rd1;
      bus.out_b       <= bus.in_use_imm ? bus.in_imm : rd2;
      bus.out_alufn   <= bus.in_alufn;
      bus.out_rd      <= legal ? bus.in_rd : '0;
      bus.out_illegal <= !legal;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for the operand/issue stage.
// Expected values are hand-computed per vector.
module tb_alu_operand_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_operand_issue_if bus ();

  alu_operand_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(
    input logic [5:0]  fn,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic        imm_sel,
    input logic [31:0] imm,
    input logic [4:0]  rd
  );
    bus.in_valid   = 1'b1;
    bus.in_alufn   = fn;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_imm = imm_sel;
    bus.in_imm     = imm;
    bus.in_rd      = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_alufn = 0; bus.in_rs1 = 0;
    bus.in_rs2 = 0; bus.in_use_imm = 0; bus.in_imm = 0;
    bus.in_rd = 0; bus.out_ready = 1; bus.wb_en = 0;
    bus.wb_addr = 0; bus.wb_data = 0;

    // reset state
    step(); step();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_a", bus.out_a, 0);
    chk("rst_b", bus.out_b, 0);
    chk("rst_rd", 32'(bus.out_rd), 0);
    chk("rst_fn", 32'(bus.out_alufn), 0);
    chk("rst_ill", 32'(bus.out_illegal), 0);
    rst = 1'b0;
    step();

    // ADD x3 = x0 + 5
    op(ALU_ADD, 0, 0, 1, 32'd5, 3);
    #1 chk("add_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_a", bus.out_a, 0);
    chk("add_b", bus.out_b, 5);
    chk("add_rd", 32'(bus.out_rd), 3);

    // RAW on x3, then resolved by forwarding
    op(ALU_SUB, 3, 0, 1, 32'd1, 4);
    #1 chk("raw_stall", 32'(bus.in_ready), 0);
    step();
    chk("raw_bubble", 32'(bus.out_valid), 0);
    wb(3, 32'h1234);
    #1 chk("raw_fwd_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0; bus.wb_en = 0;
    chk("raw_valid", 32'(bus.out_valid), 1);
    chk("raw_a", bus.out_a, 32'h1234);
    chk("raw_b", bus.out_b, 1);
    chk("raw_fn", 32'(bus.out_alufn), 32'(ALU_SUB));
    chk("raw_rd", 32'(bus.out_rd), 4);

    // backpressure for 4 cycles
    bus.out_ready = 0;
    op(ALU_AND, 3, 0, 0, 32'hdead, 5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rdy", 32'(bus.in_ready), 0);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_a", bus.out_a, 32'h1234);
      chk("bp_rd", 32'(bus.out_rd), 4);
      step();
    end
    bus.out_ready = 1;
    #1 chk("bp_release", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    chk("b2b_valid", 32'(bus.out_valid), 1);
    chk("b2b_a", bus.out_a, 32'h1234);
    chk("b2b_b", bus.out_b, 0);
    chk("b2b_fn", 32'(bus.out_alufn), 32'(ALU_AND));
    chk("b2b_rd", 32'(bus.out_rd), 5);

    // retire x4 and x5
    wb(4, 32'haa); step();
    wb(5, 32'h55); step();
    bus.wb_en = 0;

    // WAW with same-cycle clear: set wins
    op(ALU_OR, 0, 0, 1, 32'd7, 7);
    step();
    op(ALU_XOR, 0, 0, 1, 32'd1, 7);
    wb(7, 32'h77);
    #1 chk("waw_rdy", 32'(bus.in_ready), 1);
    step();
    bus.wb_en = 0;
    chk("waw_rd", 32'(bus.out_rd), 7);
    chk("waw_b", bus.out_b, 1);
    op(ALU_SUB, 7, 0, 1, 32'd0, 0);
    #1 chk("waw_pend7", 32'(bus.in_ready), 0);
    wb(7, 32'h99);
    #1 chk("waw_fwd_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0; bus.wb_en = 0;
    chk("waw_fwd_a", bus.out_a, 32'h99);

    // illegal code
    op(6'b000011, 0, 0, 1, 32'd0, 9);
    step();
    bus.in_valid = 0;
    chk("ill_flag", 32'(bus.out_illegal), 1);
    chk("ill_rd", 32'(bus.out_rd), 0);
    chk("ill_fn", 32'(bus.out_alufn), 3);
    op(ALU_ADD, 9, 0, 1, 32'd0, 0);
    #1 chk("ill_nopend", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    chk("ill_leg", 32'(bus.out_illegal), 0);

    // x0 write is dropped
    wb(0, 32'hffffffff);
    step();
    bus.wb_en = 0;
    op(ALU_ADD, 0, 0, 0, 32'd3, 0);
    step();
    bus.in_valid = 0;
    chk("x0_a", bus.out_a, 0);
    chk("x0_b", bus.out_b, 0);

    // async reset mid-cycle with valid output
    op(ALU_ADD, 3, 0, 1, 32'd1, 10);
    step();
    bus.in_valid = 0;
    bus.out_ready = 0;
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_a", bus.out_a, 32'h1235 - 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_a", bus.out_a, 0);
    rst = 1'b0;
    bus.out_ready = 1;
    op(ALU_ADD, 10, 3, 0, 32'd0, 0);
    #1 chk("arst_nopend", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    chk("arst_rf_a", bus.out_a, 0);
    chk("arst_rf_b", bus.out_b, 0);

    // late writeback after reset still lands
    wb(10, 32'hbeef);
    step();
    bus.wb_en = 0;
    op(ALU_ADD, 10, 0, 1, 32'd0, 0);
    step();
    bus.in_valid = 0;
    chk("late_wb_a", bus.out_a, 32'hbeef);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Upstream operand/issue stage that feeds the ALU.
- Holds the 32x32 architectural register file. Accepts decoded ops (alufn, rs1, rs2/imm, rd) over a valid/ready handshake.
- Tracks RAW/WAW hazards with a pending-write scoreboard and presents registered operands a, b and alufn to the ALU.
- ALU results return through the writeback port, which writes the register file, clears the scoreboard and forwards into the same-cycle read.

Parameters:
- DATA_W, 32, operand/result width.
- NUM_REGS, 32, register count; register 0 is hardwired to zero.
- ADDR_W, 5, register index width; equals clog2(NUM_REGS).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  op accepted when in_valid && in_ready at a rising edge.
- in_alufn  input  6  ALU function code.
- in_rs1  input  ADDR_W  source register for a.
- in_rs2  input  ADDR_W  source register for b; ignored when in_use_imm=1.
- in_use_imm  input  1  b = in_imm instead of reg[rs2].
- in_imm  input  DATA_W  immediate.
- in_rd  input  ADDR_W  destination register.
- out_valid  output  1  operands valid to the ALU.
- out_ready  input  1  ALU/downstream consumes when out_valid && out_ready.
- out_a  output  DATA_W  operand a.
- out_b  output  DATA_W  operand b.
- out_alufn  output  6  function code.
- out_rd  output  ADDR_W  destination tag carried to writeback.
- out_illegal  output  1  alufn is not a defined code.
- wb_en  input  1  writeback strobe.
- wb_addr  input  ADDR_W  writeback register.
- wb_data  input  DATA_W  writeback value.

Behaviour:
- Reset (async, rst=1):
  - All registers read 0 and pending[] is cleared.
  - out_valid=0; out_a, out_b, out_rd, out_alufn and out_illegal are 0.
  - in_ready may be 1 during reset; no op is accepted while rst=1.
- Reads:
  - reg 0 always reads 0.
  - Writes to reg 0 are dropped and never set pending.
- Forwarding:
  - If wb_en=1 and wb_addr=rs (rs≠0) in the same cycle, the operand takes wb_data.
  - That source is treated as not pending.
- Hazard (combinational), asserted when any of the following holds:
  - rs1≠0 and pending[rs1], not forwarded;
  - !in_use_imm and rs2≠0 and pending[rs2], not forwarded;
  - legal op with rd≠0 and pending[rd], not cleared this cycle (WAW).
- in_ready = (!out_valid || out_ready) && !hazard. It never depends on in_valid.
- Accept, 1-cycle latency:
  - On accept, the output register loads a, b, alufn, rd and illegal; out_valid=1 on the next cycle.
  - On accept of a legal op with rd≠0, set pending[rd].
- Pipeline flow:
  - Consume without a new accept: out_valid→0. Outputs keep their last values, which are don't-care.
  - Consume with accept in the same cycle: back-to-back, no bubble.
- Stall: while out_valid && !out_ready, all out_* signals hold stable.
- Scoreboard:
  - wb_en clears pending[wb_addr].
  - If a set and a clear hit the same index in one cycle, the set wins.
  - wb_en to a non-pending register still writes the file.
- Legal alufn codes: 000000..000010, 000100..000110, 001000, 001001, 001011.
- Illegal code:
  - The op is still accepted, with out_illegal=1 and out_rd=0.
  - No pending bit is set.
- Reset mid-operation: the in-flight output and all pending bits are discarded immediately. An outstanding writeback arriving after reset writes the file normally.
- Arithmetic: no width change; the immediate is used as given (no extension here).

Decomposition:
- Package alu_pkg:
  - ALUFN_W=6 and named alufn constants: ADD, SUB, MUL, AND, OR, XOR, SLL, SRL, SLT.
  - Function alufn_is_legal().
  - DATA_W and ADDR_W localparams, shared with the ALU.
- Sub-module regfile_2r1w:
  - Two combinational read ports and one write port.
  - Reg 0 tied to zero; write-through forwarding inside.
  - The scoreboard and handshake stay in the top.

Test Plan:
- Reset, then issue ADD rs1=0, imm=5, rd=3, with out_ready=1:
  - Next cycle out_valid=1, out_a=0, out_b=5, out_rd=3.
  - pending[3]=1.
- RAW stall:
  - With pending[3], present SUB rs1=3 → in_ready=0.
  - Assert wb_en, wb_addr=3, wb_data=0x1234 → in_ready=1 that cycle, and out_a=0x1234 on the next cycle.
- Backpressure:
  - out_ready=0 for 4 cycles with out_valid=1 → out_* unchanged and in_ready=0.
  - Raise out_ready with a new op pending → the new op appears the next cycle, no bubble.
- WAW and same-cycle set/clear:
  - Issue rd=7, then a second op rd=7 in the same cycle as wb_addr=7 → accepted, and pending[7] remains 1.
- Illegal code:
  - alufn=6'b000011, rd=9 → out_illegal=1, out_rd=0, pending[9]=0.
- x0 and async reset:
  - wb_en to addr 0 with 0xFFFFFFFF, then read rs1=0 → out_a=0.
  - Assert rst between clock edges with out_valid=1 → out_valid drops to 0 immediately, and all pending bits clear.
